// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AXI-Stream select demultiplexer.
package aes_uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRoute = 2'd1,
        StDrop  = 2'd2
    } demux_state_e;

    // A select with its MSB set is the reserved drop code.
    localparam logic DropCodeMsb = 1'b1;

    function automatic logic sel_is_drop(input logic [31:0] sel_v, input int unsigned sel_w,
                                         input int unsigned num_ch);
        return (sel_v[sel_w-1] == DropCodeMsb) || (sel_v >= num_ch);
    endfunction

endpackage

// File: rtl/my_axis_if.sv
// Minimal AXI-Stream bundle: tdata/tvalid/tready/tlast.
interface my_axis_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer carrying tdata+tlast; one cycle in-to-out latency.
module axis_skid_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_valid,
    input  logic              i_ready
);

    logic [DATA_W-1:0] r_data [2];
    logic              r_last [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_cnt;
    logic              w_push;
    logic              w_pop;

    // Ready depends only on the registered fill level, never on i_ready.
    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_data[r_rd_ptr];
    assign o_last  = r_last[r_rd_ptr];
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last[0] <= 1'b0;
            r_last[1] <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_cnt     <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= i_data;
                r_last[r_wr_ptr] <= i_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/axis_stream_demux_n.sv
// Packet-locked AXI-Stream 1:N demultiplexer with drop code and saturating drop counter.
module axis_stream_demux_n
    import aes_uart_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH) + 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    my_axis_if.slave         s_axis,
    my_axis_if.master        m_axis [NUM_CH],
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel,
    output logic [CNT_W-1:0] drop_cnt
);

    demux_state_e          r_state;
    demux_state_e          w_state_d;
    logic                  r_rst_done;
    logic [SEL_W-1:0]      r_cur_sel;
    logic [CNT_W-1:0]      r_drop_cnt;

    logic                  w_tready;
    logic                  w_push_en;
    logic                  w_latch;
    logic                  w_drop_inc;
    logic                  w_sel_drop;
    logic                  w_skid_ready;
    logic                  w_skid_valid;
    logic [DATA_W-1:0]     w_skid_data;
    logic                  w_skid_last;
    logic [(2**SEL_W)-1:0] w_m_tready;

    assign w_sel_drop = sel_is_drop(32'(sel), SEL_W, NUM_CH);

    always_comb begin
        w_state_d  = r_state;
        w_tready   = 1'b0;
        w_push_en  = 1'b0;
        w_latch    = 1'b0;
        w_drop_inc = 1'b0;
        case (r_state)
            StIdle: begin
                // A new packet may only start once the previous one has fully drained.
                w_tready = r_rst_done & en & ~w_skid_valid;
                if (w_tready && s_axis.tvalid) begin
                    w_latch = 1'b1;
                    if (w_sel_drop) begin
                        if (s_axis.tlast) w_drop_inc = 1'b1;
                        else              w_state_d  = StDrop;
                    end else begin
                        w_push_en = 1'b1;
                        if (!s_axis.tlast) w_state_d = StRoute;
                    end
                end
            end
            StRoute: begin
                w_tready  = w_skid_ready;
                w_push_en = 1'b1;
                if (w_skid_ready && s_axis.tvalid && s_axis.tlast) w_state_d = StIdle;
            end
            StDrop: begin
                w_tready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_drop_inc = 1'b1;
                    w_state_d  = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_rst_done <= 1'b0;
            r_cur_sel  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_rst_done <= 1'b1;
            if (w_latch) r_cur_sel <= sel;
            if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    axis_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (s_axis.tdata),
        .i_last  (s_axis.tlast),
        .i_valid (s_axis.tvalid & w_push_en),
        .o_ready (w_skid_ready),
        .o_data  (w_skid_data),
        .o_last  (w_skid_last),
        .o_valid (w_skid_valid),
        .i_ready (w_m_tready[r_cur_sel])
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        logic w_hit;
        assign w_hit             = w_skid_valid && (r_cur_sel == SEL_W'(g));
        assign m_axis[g].tvalid  = w_hit;
        assign m_axis[g].tdata   = w_hit ? w_skid_data : '0;
        assign m_axis[g].tlast   = w_hit & w_skid_last;
        assign w_m_tready[g]     = m_axis[g].tready;
    end

    for (genvar g = NUM_CH; g < (2**SEL_W); g++) begin : g_pad
        assign w_m_tready[g] = 1'b0;
    end

    assign s_axis.tready = w_tready;
    assign busy          = (r_state != StIdle) | w_skid_valid;
    assign cur_sel       = r_cur_sel;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_axis_stream_demux_n.sv
// Randomised bench for axis_stream_demux_n against a per-channel packet queue model.
module tb_axis_stream_demux_n;

    localparam int unsigned NumCh  = 4;
    localparam int unsigned DataW  = 8;
    localparam int unsigned SelW   = 3;
    localparam int unsigned CntW   = 3;
    localparam int          CntMax = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [SelW-1:0] sel;
    logic            busy;
    logic [SelW-1:0] cur_sel;
    logic [CntW-1:0] drop_cnt;

    my_axis_if #(.DATA_W(DataW)) s_if ();
    my_axis_if #(.DATA_W(DataW)) m_if [NumCh] ();

    logic [NumCh-1:0] m_rdy = 4'hf;
    logic [NumCh-1:0] m_vld;
    logic [NumCh-1:0] m_lst;
    logic [DataW-1:0] m_dat [NumCh];

    for (genvar g = 0; g < NumCh; g++) begin : g_m
        assign m_if[g].tready = m_rdy[g];
        assign m_vld[g]       = m_if[g].tvalid;
        assign m_lst[g]       = m_if[g].tlast;
        assign m_dat[g]       = m_if[g].tdata;
    end

    axis_stream_demux_n #(
        .NUM_CH (NumCh),
        .DATA_W (DataW),
        .SEL_W  (SelW),
        .CNT_W  (CntW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sel      (sel),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .busy     (busy),
        .cur_sel  (cur_sel),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected beats per channel as {tlast, tdata}, plus s-side handshake cycle.
    logic [8:0] exp_q [NumCh][$];
    int         exp_c [NumCh][$];
    int         n_drops;
    int         rdy_mode;
    bit         chk_lat;
    bit         saw_stall;
    bit         hold   [NumCh];
    logic [8:0] hold_v [NumCh];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic int pending();
        int s = 0;
        for (int g = 0; g < NumCh; g++) s += exp_q[g].size();
        return s;
    endfunction

    function automatic int sat_drops(input int n);
        return (n > CntMax) ? CntMax : n;
    endfunction

    task automatic abort_run(input string why);
        $display("FAIL %s: bound expired at t=%0t", why, $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    endtask

    task automatic ready_gen();
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       m_rdy = 4'hf;
                1:       m_rdy = 4'($urandom);
                default: m_rdy = {2'b11, (m_rdy[1] === 1'b1) ? 1'b0 : 1'b1, 1'b1};
            endcase
        end
    endtask

    task automatic monitor();
        logic [8:0] v;
        int         t;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                for (int g = 0; g < NumCh; g++) hold[g] = 1'b0;
            end else begin
                check("onehot_valid", 32'($countones(m_vld) <= 1), 32'd1);
                for (int g = 0; g < NumCh; g++) begin
                    if (m_vld[g]) begin
                        if (hold[g]) check("stable_stalled", 32'({m_lst[g], m_dat[g]}),
                                           32'(hold_v[g]));
                        if (m_rdy[g]) begin
                            hold[g] = 1'b0;
                            check("beat_expected", 32'(exp_q[g].size() != 0), 32'd1);
                            if (exp_q[g].size() != 0) begin
                                v = exp_q[g].pop_front();
                                t = exp_c[g].pop_front();
                                check("beat_data", 32'({m_lst[g], m_dat[g]}), 32'(v));
                                if (chk_lat) check("latency", cyc, t + 1);
                            end
                        end else begin
                            hold[g]   = 1'b1;
                            hold_v[g] = {m_lst[g], m_dat[g]};
                        end
                    end else begin
                        if (hold[g]) check("valid_held", 32'(m_vld[g]), 32'd1);
                        hold[g] = 1'b0;
                        check("idle_zero", 32'({m_lst[g], m_dat[g]}), 32'd0);
                    end
                end
            end
        end
    endtask

    // ch < 0 means the packet is being dropped.
    task automatic send_beat(input logic [7:0] d, input logic last, input int ch,
                             input bit must_rdy);
        int t = 0;
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        #4;
        if (must_rdy) check("drop_ready", 32'(s_if.tready), 32'd1);
        while (!s_if.tready) begin
            saw_stall = 1'b1;
            t++;
            if (t > 500) abort_run("s_tready_timeout");
            @(negedge clk);
            #4;
        end
        if (ch >= 0) begin
            exp_q[ch].push_back({last, d});
            exp_c[ch].push_back(cyc);
        end else if (last) begin
            n_drops++;
        end
        @(posedge clk);
        #1;
    endtask

    // smid < 0 randomises sel while the packet is in flight.
    task automatic send_pkt(input int s0, input int smid, input int len, input bit rnd,
                            input bit en_rand);
        int         ch;
        logic [7:0] d;
        ch  = (s0 < NumCh) ? s0 : -1;
        en  = 1'b1;
        sel = SelW'(s0);
        for (int i = 0; i < len; i++) begin
            d = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
            send_beat(d, (i == len - 1), ch, (ch < 0) && (i > 0));
            sel = (smid < 0) ? SelW'($urandom) : SelW'(smid);
            if (en_rand) en = 1'($urandom);
        end
        s_if.tvalid = 1'b0;
        en          = 1'b1;
        if (ch < 0) check("drop_cnt", 32'(drop_cnt), sat_drops(n_drops));
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clk);
        #4;
        while ((busy || pending() != 0) && t < 300) begin
            t++;
            @(negedge clk);
            #4;
        end
        check("drain_queue", pending(), 0);
        check("drain_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;
        sel         = '0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'hA5;
        s_if.tlast  = 1'b0;
        rdy_mode    = 0;
        chk_lat     = 1'b0;
        n_drops     = 0;
        saw_stall   = 1'b0;
        for (int g = 0; g < NumCh; g++) hold[g] = 1'b0;

        fork
            monitor();
            ready_gen();
            begin
                #2_000_000;
                abort_run("global_watchdog");
            end
        join_none

        // Reset state, with a valid beat waiting that must not be taken.
        @(negedge clk);
        @(negedge clk);
        #4;
        check("rst_tready", 32'(s_if.tready), 32'd0);
        check("rst_mvalid", 32'(m_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_sel", 32'(cur_sel), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("rst_release_tready", 32'(s_if.tready), 32'd0);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;

        // sel=2, 0x11..0x44, all ready, latency 1.
        chk_lat = 1'b1;
        send_pkt(2, 2, 4, 1'b0, 1'b0);
        // sel changes to 0 mid-packet; next packet goes to channel 0.
        send_pkt(2, 0, 4, 1'b0, 1'b0);
        send_pkt(0, 3, 3, 1'b1, 1'b0);
        wait_drain();

        // Drop code: 3 beats, tready high throughout, counter 0 -> 1.
        send_pkt(5, 1, 3, 1'b1, 1'b1);
        wait_drain();

        // Single-beat routed packet: busy for exactly one cycle.
        sel = 3'd3;
        en  = 1'b1;
        send_beat(8'h77, 1'b1, 3, 1'b0);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        #4;
        check("single_busy_hi", 32'(busy), 32'd1);
        check("single_cur_sel", 32'(cur_sel), 32'd3);
        @(negedge clk);
        #4;
        check("single_busy_lo", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Channel 1 ready toggling: buffer fills, all beats in order.
        chk_lat   = 1'b0;
        rdy_mode  = 2;
        saw_stall = 1'b0;
        send_pkt(1, 1, 8, 1'b1, 1'b0);
        check("skid_full_stall", 32'(saw_stall), 32'd1);
        wait_drain();
        rdy_mode = 0;

        // en low gates packet start.
        @(negedge clk);
        en          = 1'b0;
        sel         = 3'd1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h5A;
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #4;
            check("en_gate", 32'(s_if.tready), 32'd0);
            @(negedge clk);
        end
        en = 1'b1;
        #4;
        check("en_accept", 32'(s_if.tready), 32'd1);
        exp_q[1].push_back({1'b0, 8'h5A});
        exp_c[1].push_back(cyc);
        @(posedge clk);
        #1;
        send_beat(8'h5B, 1'b1, 1, 1'b0);
        s_if.tvalid = 1'b0;
        wait_drain();

        // Drop counter saturation.
        for (int k = 0; k < 8; k++) send_pkt(4 + (k % 4), -1, 1 + (k % 2), 1'b1, 1'b1);
        check("drop_saturated", 32'(drop_cnt), CntMax);

        // Reset after beat 2 of a 4-beat packet.
        send_beat(8'h11, 1'b0, 2, 1'b0);
        sel = 3'd0;
        send_beat(8'h22, 1'b0, 2, 1'b0);
        @(negedge clk);
        rst_n       = 1'b0;
        s_if.tvalid = 1'b0;
        for (int g = 0; g < NumCh; g++) begin
            exp_q[g].delete();
            exp_c[g].delete();
        end
        n_drops = 0;
        #4;
        check("midrst_mvalid", 32'(m_vld), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("midrst_tready", 32'(s_if.tready), 32'd0);
        check("midrst_cur_sel", 32'(cur_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(2, 1, 4, 1'b0, 1'b0);
        wait_drain();

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            rdy_mode = int'($urandom_range(0, 1));
            send_pkt(int'($urandom_range(0, 7)), -1, int'($urandom_range(1, 6)), 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        wait_drain();
        check("final_drop_cnt", 32'(drop_cnt), sat_drops(n_drops));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_stream_demux_n.md
AXIS_STREAM_DEMUX_N -- requirements
Module: axis_stream_demux_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of master channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 8, tdata width of all streams.
REQ-003 SHALL have parameter SEL_W, default $clog2(NUM_CH)+1, select width (MSB reserves a drop code).
REQ-004 SHALL have parameter CNT_W, default 16, drop-counter width.
REQ-005 Port: clk  input  1  single clock, all logic rising-edge.
REQ-006 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port: en  input  1  enables acceptance of new packets.
REQ-008 Port: sel  input  SEL_W  destination channel, sampled at packet start.
REQ-009 Port: s_axis  my_axis_if.slave  DATA_W  input stream (tdata/tvalid/tready/tlast).
REQ-010 Port: m_axis[NUM_CH]  my_axis_if.master  DATA_W  output stream array.
REQ-011 Port: busy  output  1  high while a packet is locked to a destination.
REQ-012 Port: cur_sel  output  SEL_W  locked destination, valid while busy.
REQ-013 Port: drop_cnt  output  CNT_W  count of discarded packets, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, ROUTE, DROP.
REQ-015 IDLE: s_axis.tready SHALL be 0 when en=0; no beat is accepted.
REQ-016 IDLE, en=1, s_axis.tvalid=1: sel SHALL be latched into cur_sel in that cycle; sel<NUM_CH -> ROUTE, else -> DROP.
REQ-017 The first beat SHALL be handled in the same cycle as the latch (no bubble): forwarded in ROUTE, discarded in DROP.
REQ-018 sel changes while busy SHALL be ignored until the tlast handshake completes.
REQ-019 ROUTE: beats SHALL pass through a 2-entry skid buffer to m_axis[cur_sel]; s_axis.tready = skid buffer not full.
REQ-020 Forward latency SHALL be 1 cycle (s_axis handshake at cycle N -> m_axis tvalid at N+1); throughput 1 beat/cycle with tready held high.
REQ-021 Non-selected m_axis channels SHALL drive tvalid=0, tdata=0, tlast=0.
REQ-022 m_axis tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-023 On the tlast handshake at s_axis, FSM SHALL return to IDLE; the buffer SHALL drain to the old channel before beats of the next packet reach any output.
REQ-024 Next packet SHALL NOT be accepted until the skid buffer is empty (prevents interleaving).
REQ-025 DROP: s_axis.tready SHALL be 1; beats discarded; on tlast handshake drop_cnt SHALL increment by 1 and FSM SHALL return to IDLE.
REQ-026 drop_cnt SHALL saturate at all-ones, never wrap.
REQ-027 en deasserted mid-packet SHALL NOT stall or truncate the current packet; it only gates the next IDLE->ROUTE/DROP transition.
REQ-028 Single-beat packet (tvalid & tlast on first beat) SHALL transition IDLE->ROUTE/DROP->IDLE correctly; busy SHALL be high for exactly that cycle's registered window (1 cycle).
REQ-029 busy SHALL be 1 in ROUTE/DROP or while skid buffer is non-empty.

Reset
REQ-030 rst_n=0 SHALL force FSM to IDLE, empty the skid buffer, busy=0, cur_sel=0, drop_cnt=0, all m_axis tvalid=0, s_axis.tready=0.
REQ-031 Reset mid-packet SHALL discard buffered beats without emitting a partial tlast.
REQ-032 Deassertion SHALL take effect on the first clk edge after rst_n rises; no beat accepted in that same cycle.

Structure
REQ-033 FSM state enum and the drop-code constant SHALL reside in shared package aes_uart_pkg.
REQ-034 Skid buffer SHALL be sub-module axis_skid_buf (DATA_W parameter, tdata+tlast storage).
REQ-035 Demux of the skid-buffer output SHALL be combinational on registered cur_sel only.

Verification
REQ-036 NUM_CH=4, sel=2, 4-beat packet 0x11..0x44, all tready=1 -> m_axis[2] emits 0x11..0x44, tlast on 0x44, 1-cycle latency; others silent.
REQ-037 sel changed 2->0 after beat 1 -> whole packet on m_axis[2]; next packet on m_axis[0].
REQ-038 sel=5 (>=NUM_CH), 3-beat packet -> tready=1 throughout, no output, drop_cnt 0->1.
REQ-039 m_axis[1].tready toggled 1010..., 8-beat packet -> s_axis.tready drops when buffer full; all 8 beats delivered in order, no duplication.
REQ-040 en=0 with tvalid=1 -> tready=0 for 5 cycles; en=1 -> packet accepted next cycle.
REQ-041 rst_n pulsed low after beat 2 of a 4-beat packet -> all tvalid=0, drop_cnt=0, FSM IDLE; fresh packet after reset routes normally.
